alu_mul_ctrl: RTL

Parametrised ALU control unit with an attached iterative multiplier sequencer for the pipelined CPU. It decodes ALUOp/funct into the 4-bit ALU operation code, like the previous ALU control, and flags undefined encodings instead of holding a stale value. It also runs R-format `mult` as a multi-cycle shift-add operation, with a busy/done handshake to the hazard unit and HI/LO result registers. It sits in the EX stage beside the ALU.

---
 rtl/alu_mul_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_mul_ctrl.sv
// alu_mul_ctrl: EX-stage ALU control decoder with an attached shift-add
// multiplier sequencer. The decoder maps ALUOp/funct to the 4-bit ALU
// operation code and flags undefined encodings. R-format mult runs as a
// WIDTH-cycle iterative multiply. Its result goes to the HI/LO registers
// and is reported with a busy/done handshake to the hazard unit.
//
// Build option: define ALU_MUL_MULTU_EN to decode funct 011001 (multu) as
// an unsigned multiply. Without it, multu is reported as illegal.
module alu_mul_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic                    flush_i,
  input  logic [2:0]              ALUOp_i,
  input  logic [5:0]              funct_i,
  input  logic signed [WIDTH-1:0] src1_i,
  input  logic signed [WIDTH-1:0] src2_i,
  output logic [3:0]              ALUCtrl_o,
  output logic                    illegal_o,
  output logic                    mul_busy_o,
  output logic                    mul_done_o,
  output logic [WIDTH-1:0]        hi_o,
  output logic [WIDTH-1:0]        lo_o
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic                undefined;
  logic                is_mul;
  logic                mul_signed;
  logic                start;
  logic                last;

  logic [CNT_W-1:0]    cnt;
  logic [PROD_W-1:0]   acc;
  logic [PROD_W-1:0]   acc_nxt;
  logic [PROD_W-1:0]   mcand;
  logic [WIDTH-1:0]    mplier;
  logic                sign;

  // Unsigned magnitude of an operand. The most negative value negates to
  // itself, and that bit pattern read as unsigned is exactly 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(
    input logic signed [WIDTH-1:0] v,
    input logic                    as_signed
  );
    logic [WIDTH-1:0] neg_v;
    neg_v = -v;
    if (as_signed && v[WIDTH-1]) begin
      return neg_v;
    end
    return v;
  endfunction

  // Restore the product sign. The result is taken modulo 2^(2*WIDTH).
  function automatic logic [PROD_W-1:0] apply_sign(
    input logic [PROD_W-1:0] a,
    input logic              neg
  );
    return neg ? -a : a;
  endfunction

  // Decode ALUOp/funct into the ALU operation code and the multiply request.
  always_comb begin
    ALUCtrl_o  = 4'b1111;
    undefined  = 1'b1;
    is_mul     = 1'b0;
    mul_signed = 1'b0;
    case (ALUOp_i)
      3'b000: begin ALUCtrl_o = 4'b0010; undefined = 1'b0; end
      3'b001: begin ALUCtrl_o = 4'b0110; undefined = 1'b0; end
      3'b010: begin ALUCtrl_o = 4'b0111; undefined = 1'b0; end
      3'b100: begin
        case (funct_i)
          6'b100000: begin ALUCtrl_o = 4'b0010; undefined = 1'b0; end
          6'b100010: begin ALUCtrl_o = 4'b0110; undefined = 1'b0; end
          6'b100100: begin ALUCtrl_o = 4'b0000; undefined = 1'b0; end
          6'b100101: begin ALUCtrl_o = 4'b0001; undefined = 1'b0; end
          6'b101010: begin ALUCtrl_o = 4'b0111; undefined = 1'b0; end
          6'b011000: begin
            ALUCtrl_o  = 4'b0011;
            undefined  = 1'b0;
            is_mul     = 1'b1;
            mul_signed = 1'b1;
          end
`ifdef ALU_MUL_MULTU_EN
          6'b011001: begin
            ALUCtrl_o  = 4'b0011;
            undefined  = 1'b0;
            is_mul     = 1'b1;
            mul_signed = 1'b0;
          end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign illegal_o = valid_i & undefined;

  // Start is only accepted when no multiply is running. A flush overrides
  // any start request in the same cycle.
  assign start = valid_i & is_mul & ~flush_i & ((state == IDLE) || (state == DONE));
  assign last  = (cnt == CNT_W'(WIDTH - 1));

  // One shift-add step: add the shifted multiplicand when multiplier bit 0 is set.
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (flush_i) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, iteration counter and HI/LO result registers. HI/LO are
  // written on entry to DONE, using the accumulator value from the final step.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc  <= '0;
      cnt  <= '0;
      hi_o <= '0;
      lo_o <= '0;
    end else if (start) begin
      acc <= '0;
      cnt <= '0;
    end else if ((state == RUN) && !flush_i) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (last) begin
        {hi_o, lo_o} <= apply_sign(acc_nxt, sign);
      end
    end
  end

  // Operand shift registers. They are loaded at start and shifted each RUN
  // cycle. They need no reset because the accumulator is cleared before use.
  always_ff @(posedge clk_i) begin
    if (start) begin
      mcand  <= {{WIDTH{1'b0}}, magnitude(src1_i, mul_signed)};
      mplier <= magnitude(src2_i, mul_signed);
      sign   <= mul_signed & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
    end else if (state == RUN) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign mul_busy_o = (state == RUN);
  assign mul_done_o = (state == DONE);

endmodule
